btn_debounce: RTL and testbench

Input conditioning stage for a push-button feeding the traffic-light controller. It synchronises the raw asynchronous button pin, rejects contact bounce with a stable-window counter, and produces a clean level plus single-cycle press, release and long-press pulses. Its `press` output drives the controller's `btn` input in the traffic-light top level, replacing the raw pin connection.

---
 rtl/btn_pkg.sv | 17 +
 rtl/sync_ff.sv | 29 ++
 rtl/btn_debounce.sv | 127 ++++++++++++
 tb/tb_btn_debounce.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioning stage.
package btn_pkg;

  // Debounce FSM states: two stable levels, each with a qualifying check state
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } state_t;

  // Default parameter values
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned LONG_CYCLES_DEF     = 1024;

endpackage : btn_pkg

// File: rtl/sync_ff.sv
// Multi-stage flop chain bringing an asynchronous single-bit input into clk.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Reject unsafe depths at elaboration time
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  // Shift the input through the chain; oldest sample is the output
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : sync_ff

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit press / release /
// long-press pulses. The release pulse port is named release_pulse because
// "release" is a reserved word in SystemVerilog.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic btn_raw,
  output logic btn,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

  // The sample that leaves the stable state counts as the first of the run,
  // so the check state needs DEBOUNCE_CYCLES-1 further matching samples.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  // Reject parameter values the counters cannot honour
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("btn_debounce: LONG_CYCLES must be at least 1");
  end

  logic          s_in;
  state_t        state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  logic          hold_sat_c;
  logic [HW-1:0] hold_inc_c;
  logic          long_hit_c;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .res (res),
    .d   (btn_raw),
    .q   (s_in)
  );

  // Saturating hold-count step and the one-shot long-press condition
  always_comb begin
    hold_sat_c = (hold_cnt == HOLD_MAX);
    hold_inc_c = hold_sat_c ? hold_cnt : hold_cnt + HW'(1);
    long_hit_c = !hold_sat_c && (hold_inc_c == HOLD_MAX);
  end

  // Debounce FSM with counters and registered outputs
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state         <= S_IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      btn           <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (s_in) begin
            state   <= S_PRESS_CHK;
            deb_cnt <= '0;
          end
        end
        S_PRESS_CHK: begin
          if (!s_in) begin
            state <= S_IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= S_HELD;
            btn      <= 1'b1;
            press    <= 1'b1;
            hold_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        S_HELD: begin
          hold_cnt   <= hold_inc_c;
          long_press <= long_hit_c;
          if (!s_in) begin
            state   <= S_REL_CHK;
            deb_cnt <= '0;
          end
        end
        S_REL_CHK: begin
          if (s_in) begin
            // Bounce during release: hold time keeps accumulating
            state      <= S_HELD;
            hold_cnt   <= hold_inc_c;
            long_press <= long_hit_c;
          end else if (deb_cnt == DEB_LAST) begin
            // Release wins; a long press landing on this edge is dropped
            state         <= S_IDLE;
            btn           <= 1'b0;
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
          end else begin
            deb_cnt    <= deb_cnt + DW'(1);
            hold_cnt   <= hold_inc_c;
            long_press <= long_hit_c;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce against a run-length reference model.
module tb_btn_debounce;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int          PRESS_LAT = SYNC + DEB - 1;

  logic clk = 1'b0;
  logic res;
  logic btn_raw;
  logic btn, press, release_pulse, long_press;

  always #5 clk = ~clk;

  btn_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk           (clk),
    .res           (res),
    .btn_raw       (btn_raw),
    .btn           (btn),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  // Reference model: raw samples delayed by the synchroniser, then run lengths
  logic hist [SYNC];
  int   ones_run, zeros_run, held;
  logic m_btn, e_press, e_rel, e_long;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_press, n_rel, n_long;
  int press_cyc, rel_cyc, long_cyc;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
    ones_run = 0; zeros_run = 0; held = 0;
    m_btn = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
  endtask

  task automatic model_edge(input logic v);
    logic s;
    s = hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    if (s) begin ones_run++; zeros_run = 0; end
    else begin zeros_run++; ones_run = 0; end
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (!m_btn && ones_run >= DEB) begin
      m_btn = 1'b1; e_press = 1'b1; held = 0;
    end else if (m_btn && zeros_run >= DEB) begin
      m_btn = 1'b0; e_rel = 1'b1;
    end else if (m_btn) begin
      held++;
      if (held == LONG) e_long = 1'b1;
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0;
    press_cyc = -1; rel_cyc = -1; long_cyc = -1;
  endtask

  // One clock: drive, advance model on the edge, compare 1 time unit later
  task automatic tick(input logic v);
    btn_raw = v;
    @(posedge clk);
    cyc++;
    if (res) model_reset();
    else model_edge(v);
    #1;
    check_bit("btn", btn, m_btn);
    check_bit("press", press, e_press);
    check_bit("release", release_pulse, e_rel);
    check_bit("long_press", long_press, e_long);
    if (press === 1'b1) begin n_press++; press_cyc = cyc; end
    if (release_pulse === 1'b1) begin n_rel++; rel_cyc = cyc; end
    if (long_press === 1'b1) begin n_long++; long_cyc = cyc; end
  endtask

  task automatic ticks(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  // Hold a level until the given pulse count moves, bounded
  task automatic press_and_wait(output int t0);
    int start;
    t0 = cyc + 1;
    start = n_press;
    for (int i = 0; i < 40 && n_press == start; i++) tick(1'b1);
    check_int("press_seen", n_press - start, 1);
  endtask

  task automatic release_and_wait(output int r0);
    int start;
    r0 = cyc + 1;
    start = n_rel;
    for (int i = 0; i < 40 && n_rel == start; i++) tick(1'b0);
    check_int("release_seen", n_rel - start, 1);
  endtask

  initial begin
    int t0, r0, len;
    logic v;

    // Reset state
    model_reset();
    clear_counts();
    res = 1'b1;
    btn_raw = 1'b0;
    ticks(1'b0, 3);
    res = 1'b0;
    ticks(1'b0, 6);

    // Clean press then clean release
    clear_counts();
    press_and_wait(t0);
    check_int("press_latency", press_cyc - t0, PRESS_LAT);
    ticks(1'b1, 4);
    check_int("press_once", n_press, 1);
    release_and_wait(r0);
    check_int("release_latency", rel_cyc - r0, PRESS_LAT);
    check_int("no_long_short", n_long, 0);
    ticks(1'b0, 4);

    // Press bounce then stable
    clear_counts();
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    check_int("bounce_no_press", n_press, 0);
    press_and_wait(t0);
    check_int("bounce_press_latency", press_cyc - t0, PRESS_LAT);
    ticks(1'b1, 6);
    check_int("bounce_press_once", n_press, 1);
    release_and_wait(r0);
    ticks(1'b0, 4);

    // Long press, then keep holding: no repeat
    clear_counts();
    press_and_wait(t0);
    ticks(1'b1, LONG + 100);
    check_int("long_once", n_long, 1);
    check_int("long_delay", long_cyc - press_cyc, LONG);
    release_and_wait(r0);
    check_int("long_before_release", int'(long_cyc < rel_cyc), 1);
    ticks(1'b0, 4);

    // Release bounce during hold keeps the long-press schedule
    clear_counts();
    press_and_wait(t0);
    ticks(1'b1, 8);
    ticks(1'b0, 2);
    ticks(1'b1, 25);
    check_int("relbounce_no_release", n_rel, 0);
    check_bit("relbounce_btn", btn, 1'b1);
    check_int("relbounce_long_delay", long_cyc - press_cyc, LONG);
    release_and_wait(r0);
    ticks(1'b0, 4);

    // Short press: release before the long count
    clear_counts();
    press_and_wait(t0);
    ticks(1'b1, 10);
    release_and_wait(r0);
    check_int("short_release_latency", rel_cyc - r0, PRESS_LAT);
    check_int("short_no_long", n_long, 0);
    ticks(1'b0, 25);
    check_int("short_no_long_late", n_long, 0);

    // Reset mid-hold: outputs drop at once, no release, fresh press after
    clear_counts();
    press_and_wait(t0);
    ticks(1'b1, 12);
    res = 1'b1;
    #1;
    check_bit("rst_btn", btn, 1'b0);
    check_bit("rst_press", press, 1'b0);
    check_bit("rst_release", release_pulse, 1'b0);
    check_bit("rst_long", long_press, 1'b0);
    ticks(1'b1, 2);
    res = 1'b0;
    check_int("rst_no_release", n_rel, 0);
    n_press = 0;
    press_and_wait(t0);
    check_int("rst_repress_latency", press_cyc - t0, PRESS_LAT);
    release_and_wait(r0);
    ticks(1'b0, 4);

    // Random bursts against the model
    for (int seg = 0; seg < 120; seg++) begin
      v = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEB, 30))
                                        : int'($urandom_range(1, DEB));
      ticks(v, len);
    end
    ticks(1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_btn_debounce
